// File: rtl/drbg_pkg.sv
// Shared definitions for the CTR_DRBG (AES-256, no derivation function) blocks:
// fixed sizes, the engine FSM state type and the AES S-box helpers.
package drbg_pkg;

    localparam int SEEDLEN    = 384;
    localparam int KEYLEN     = 256;
    localparam int BLOCKLEN   = 128;
    localparam int AES_LAT    = 15;
    localparam int AES_ROUNDS = AES_LAT - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_FINAL,
        ST_DONE
    } drbg_state_e;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_ROM[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/ctr_drbg_instantiate_aes.sv
// Iterative AES-256 encryptor: one load/AddRoundKey cycle, then one round per
// cycle with the key schedule expanded on the fly. done pulses for one cycle
// AES_LAT cycles after the start pulse; block_out holds until the next start.
module aes256_encrypt
    import drbg_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEYLEN-1:0]   key,
    input  logic [BLOCKLEN-1:0] block_in,
    output logic [BLOCKLEN-1:0] block_out,
    output logic                done
);

    logic [127:0] state_q;
    logic [127:0] rk_prev;   // round key r-1
    logic [127:0] rk_cur;    // round key r, applied by the round now running
    logic [3:0]   rnd;
    logic         busy;
    logic [127:0] sb_sr;
    logic [127:0] round_out;
    logic [127:0] rk_next;
    logic         last_round;

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
    endfunction

    // Byte 0 is the MSB; the state is column-major, so row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        return {s[127:120], s[87:80],   s[47:40],  s[7:0],
                s[95:88],   s[55:48],   s[15:8],   s[103:96],
                s[63:56],   s[23:16],   s[111:104], s[71:64],
                s[31:24],   s[119:112], s[79:72],  s[39:32]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
    endfunction

    // Round key idx from keys idx-2 and idx-1; even keys take RotWord and Rcon.
    function automatic logic [127:0] expand_key(input logic [127:0] prev,
                                                input logic [127:0] cur,
                                                input logic [3:0]   idx);
        logic [31:0] t, w0, w1, w2, w3;
        logic [7:0]  rcon;
        rcon = 8'h01 << (idx[3:1] - 3'd1);
        if (!idx[0])
            t = sub_word({cur[23:0], cur[31:24]}) ^ {rcon, 24'h0};
        else
            t = sub_word(cur[31:0]);
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64]  ^ w0;
        w2 = prev[63:32]  ^ w1;
        w3 = prev[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign sb_sr      = shift_rows(sub_bytes(state_q));
    assign last_round = (rnd == 4'(AES_ROUNDS));
    assign round_out  = (last_round ? sb_sr : mix_columns(sb_sr)) ^ rk_cur;
    assign rk_next    = expand_key(rk_prev, rk_cur, rnd + 4'd1);
    assign block_out  = state_q;

    // Load with round key 0, then run rounds 1..14 and pulse done on the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            rk_prev <= '0;
            rk_cur  <= '0;
            rnd     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            done <= 1'b0;
            if (start && !busy) begin
                state_q <= block_in ^ key[255:128];
                rk_prev <= key[255:128];
                rk_cur  <= key[127:0];
                rnd     <= 4'd1;
                busy    <= 1'b1;
            end else if (busy) begin
                state_q <= round_out;
                rk_prev <= rk_cur;
                rk_cur  <= rk_next;
                rnd     <= rnd + 4'd1;
                if (last_round) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ctr_drbg_instantiate.sv
// CTR_DRBG instantiate: seed = entropy ^ personalization, then CTR_DRBG_Update
// from Key = 0, V = 0. Three AES blocks (V = 1, 2, 3) form temp, which is XORed
// with the seed into the initial Key and V.
module ctr_drbg_instantiate
    import drbg_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SEEDLEN-1:0]  entropy_input,
    input  logic [SEEDLEN-1:0]  personalization_string,
    output logic [KEYLEN-1:0]   initial_key,
    output logic [BLOCKLEN-1:0] initial_v,
    output logic [31:0]         reseed_counter,
    output logic                done
);

    drbg_state_e         state, state_next;
    logic [1:0]          blk_idx;
    logic [BLOCKLEN-1:0] v_ctr;
    logic [BLOCKLEN-1:0] v_inc;
    logic [BLOCKLEN-1:0] aes_out;
    logic [SEEDLEN-1:0]  seed;
    logic [SEEDLEN-1:0]  temp;
    logic                aes_start;
    logic                aes_done;
    logic                accept;

    assign v_inc  = v_ctr + BLOCKLEN'(1);
    assign accept = start && (state == ST_IDLE || state == ST_DONE);

    // Key stays zero for the whole update, so the core key is tied off.
    aes256_encrypt u_aes (
        .clk       (clk),
        .rst       (rst),
        .start     (aes_start),
        .key       ({KEYLEN{1'b0}}),
        .block_in  (v_inc),
        .block_out (aes_out),
        .done      (aes_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic: three LOAD/WAIT passes, then FINAL.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_next = ST_LOAD;
            ST_LOAD:          state_next = ST_WAIT;
            ST_WAIT:          if (aes_done) state_next = (blk_idx == 2'd2) ? ST_FINAL : ST_LOAD;
            ST_FINAL:         state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state.
    always_comb begin
        aes_start = (state == ST_LOAD);
        done      = (state == ST_DONE);
    end

    // Datapath: capture seed, step V, collect blocks, publish the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: datapath registers are cleared too, so an aborted run leaves no seed material.
            blk_idx        <= '0;
            v_ctr          <= '0;
            seed           <= '0;
            temp           <= '0;
            initial_key    <= '0;
            initial_v      <= '0;
            reseed_counter <= '0;
        end else begin
            if (accept) begin
                seed    <= entropy_input ^ personalization_string;
                v_ctr   <= '0;
                blk_idx <= '0;
            end
            if (state == ST_LOAD)
                v_ctr <= v_inc;
            if (state == ST_WAIT && aes_done) begin
                case (blk_idx)
                    2'd0:    temp[383:256] <= aes_out;
                    2'd1:    temp[255:128] <= aes_out;
                    default: temp[127:0]   <= aes_out;
                endcase
                blk_idx <= blk_idx + 2'd1;
            end
            if (state == ST_FINAL) begin
                {initial_key, initial_v} <= temp ^ seed;
                reseed_counter           <= 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ctr_drbg_instantiate.sv
// Self-checking bench for ctr_drbg_instantiate: a software AES-256 / DRBG model
// predicts every output on every cycle; directed runs cover reset, nominal,
// zero seed, busy start, back-to-back and mid-run reset; random traffic follows.
module tb_ctr_drbg_instantiate;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [383:0] entropy_input = '0;
    logic [383:0] personalization_string = '0;
    logic [255:0] initial_key;
    logic [127:0] initial_v;
    logic [31:0]  reseed_counter;
    logic         done;

    logic         kat_start = 1'b0;
    logic [255:0] kat_key = '0;
    logic [127:0] kat_pt = '0;
    logic [127:0] kat_ct;
    logic         kat_done;

    int n_checks = 0;
    int n_errors = 0;

    ctr_drbg_instantiate dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .entropy_input          (entropy_input),
        .personalization_string (personalization_string),
        .initial_key            (initial_key),
        .initial_v              (initial_v),
        .reseed_counter         (reseed_counter),
        .done                   (done)
    );

    aes256_encrypt u_kat (
        .clk       (clk),
        .rst       (rst),
        .start     (kat_start),
        .key       (kat_key),
        .block_in  (kat_pt),
        .block_out (kat_ct),
        .done      (kat_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- software reference: GF(2^8), S-box from inverse, AES-256
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] r, p, e, b;
        r = 8'h01; p = x; e = 8'd254;   // x^254 is the field inverse (0 maps to 0)
        for (int k = 0; k < 8; k++) begin
            if (e[k]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] ref_subw(input logic [31:0] t);
        return {ref_sbox(t[31:24]), ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
    endfunction

    function automatic logic [127:0] ref_aes(input logic [255:0] key, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rcon, a0, a1, a2, a3;
        logic [127:0] res;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp  = ref_subw({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = ref_subw(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
        for (int rd = 1; rd <= 14; rd++) begin
            for (int b = 0; b < 16; b++) t[b] = ref_sbox(s[(b%4) + 4*(((b/4) + (b%4)) % 4)]);
            if (rd < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
                    s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
                end
            end else begin
                s = t;
            end
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*rd + b/4][31-8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
        return res;
    endfunction

    // Key||V after instantiate: Update from K = 0, V = 0 with the given seed.
    function automatic logic [383:0] ref_drbg(input logic [383:0] seed);
        return {ref_aes('0, 128'd1), ref_aes('0, 128'd2), ref_aes('0, 128'd3)} ^ seed;
    endfunction

    function automatic logic [383:0] rand384();
        logic [383:0] r;
        r = '0;
        for (int k = 0; k < 12; k++) r = {r[351:0], $urandom()};
        return r;
    endfunction

    // ---------------- cycle model: a run finishes 49 edges after the accepting edge
    logic         exp_done = 1'b0;
    logic [255:0] exp_key = '0;
    logic [127:0] exp_v = '0;
    logic [31:0]  exp_rc = '0;
    logic [383:0] pend_result = '0;
    int           remaining = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_done  <= 1'b0;
            exp_key   <= '0;
            exp_v     <= '0;
            exp_rc    <= '0;
            remaining <= 0;
        end else if (remaining > 0) begin
            remaining <= remaining - 1;
            if (remaining == 1) begin
                {exp_key, exp_v} <= pend_result;
                exp_rc           <= 32'd1;
                exp_done         <= 1'b1;
            end
        end else if (start) begin
            pend_result <= ref_drbg(entropy_input ^ personalization_string);
            remaining   <= 49;
            exp_done    <= 1'b0;
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        check("done", done, exp_done);
        check("reseed_counter", reseed_counter, exp_rc);
        check("initial_key", initial_key, exp_key);
        check("initial_v", initial_v, exp_v);
    end

    // One run: start pulse, optional second pulse while busy, returns edges to done.
    task automatic run(input logic [383:0] e, input logic [383:0] p, input int busy_at,
                       output int lat);
        @(posedge clk); #2;
        entropy_input = e; personalization_string = p; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 80 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (n == 1) check("done_low_after_start", done, 1'b0);
            if (done) lat = n;
            #1;
            if (n == busy_at && lat < 0) begin
                start = 1'b1; entropy_input = ~e;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           lat;
        logic [383:0] e, r;

        // Reset held for 100 ns with start asserted throughout.
        entropy_input = rand384();
        start = 1'b1;
        repeat (10) @(posedge clk);
        #2; rst = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", done, 1'b0);
        check("reset_key", initial_key, 256'h0);
        check("reset_v", initial_v, 128'h0);
        check("reset_rc", reseed_counter, 32'h0);

        // Pin the reference model to published vectors.
        check("model_fips197_c3",
              ref_aes(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                      128'h00112233445566778899aabbccddeeff),
              128'h8ea2b7ca516745bfeafc49904b496089);
        check("model_zero_key_zero_pt", ref_aes('0, '0), 128'hdc95c078a2408989ad48a21492842087);

        // AES core on FIPS-197 C.3: done cycle is 15 cycles after the start cycle.
        @(posedge clk); #2;
        kat_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        kat_pt  = 128'h00112233445566778899aabbccddeeff;
        kat_start = 1'b1;
        @(posedge clk); #2;
        kat_start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (kat_done) lat = n;
        end
        check("aes_core_latency_edges", lat, 14);
        check("aes_core_fips197_c3", kat_ct, 128'h8ea2b7ca516745bfeafc49904b496089);

        // Nominal run.
        e = {6{64'h123456789ABCDEF0}};
        run(e, '0, 0, lat);
        r = ref_drbg(e);
        check("nominal_latency", lat, 49);
        check("nominal_key", initial_key, r[383:128]);
        check("nominal_v", initial_v, r[127:0]);
        check("nominal_rc", reseed_counter, 32'd1);

        // Zero seed: result is the raw keystream.
        e = {48{8'hA5}};
        run(e, e, 0, lat);
        check("zero_seed_latency", lat, 49);
        check("zero_seed_key", initial_key, {ref_aes('0, 128'd1), ref_aes('0, 128'd2)});
        check("zero_seed_v", initial_v, ref_aes('0, 128'd3));

        // Start again at cycle 10 of a run with different data: ignored.
        e = rand384();
        run(e, '0, 9, lat);
        r = ref_drbg(e);
        check("busy_start_latency", lat, 49);
        check("busy_start_key", initial_key, r[383:128]);
        check("busy_start_v", initial_v, r[127:0]);

        // Back-to-back from DONE with new entropy.
        e = rand384();
        run(e, rand384(), 0, lat);
        check("back_to_back_latency", lat, 49);

        // Reset in the middle of a run, then a fresh run.
        @(posedge clk); #2;
        entropy_input = rand384(); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #2; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrun_reset_done", done, 1'b0);
        check("midrun_reset_key", initial_key, 256'h0);
        check("midrun_reset_v", initial_v, 128'h0);
        check("midrun_reset_rc", reseed_counter, 32'h0);
        #1; rst = 1'b0;
        repeat (60) @(posedge clk);
        e = rand384();
        run(e, '0, 0, lat);
        r = ref_drbg(e);
        check("after_reset_latency", lat, 49);
        check("after_reset_key", initial_key, r[383:128]);

        // Random traffic; the per-cycle compare does the checking.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 11) == 0);
            entropy_input = rand384();
            personalization_string = ($urandom_range(0, 1) == 1) ? rand384() : '0;
            rst = ($urandom_range(0, 399) == 0);
        end
        @(posedge clk); #2;
        start = 1'b0; rst = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
